station_operand_set: RTL
========================

# station_operand_set

Operand-collection block for one reservation-station entry, holding OPERAND_COUNT source operands per entry. Each operand is preloaded at allocation or captured by tag from any of BUS_COUNT result buses. The block adds explicit entry state, an allocation handshake, dispatch and flush handling, and an aggregate ready flag. It sits between the issue stage, which allocates, and the dispatch arbiter, which consumes `ready` and returns `dispatch`.

## Interface
Parameters:
- SIZE, 32, operand width in bits
- STATION_INDEX_SIZE, 1, width of a producer tag
- BUS_COUNT, 1, number of result buses snooped
- OPERAND_COUNT, 2, number of operands per entry

Ports (flattened arrays; element k occupies bits [(k+1)*W-1 : k*W]):
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- alloc_valid  in  1  issue requests allocation of this entry
- alloc_ready  out  1  entry is EMPTY and can accept an allocation
- alloc_preload  in  OPERAND_COUNT  per operand: 1 = value supplied now, 0 = wait for tag
- alloc_value  in  SIZE*OPERAND_COUNT  preloaded values
- alloc_source  in  STATION_INDEX_SIZE*OPERAND_COUNT  producer tags for non-preloaded operands
- dispatch  in  1  arbiter takes the entry; honoured only while `ready`=1
- flush  in  1  squash the entry
- occupied  out  1  entry state is not EMPTY
- ready  out  1  occupied and all operands loaded
- loaded  out  OPERAND_COUNT  per-operand loaded flag
- value  out  SIZE*OPERAND_COUNT  operand values, valid where `loaded` is 1
- bus_asserted  in  BUS_COUNT  bus k carries a result this cycle
- bus_source  in  STATION_INDEX_SIZE*BUS_COUNT  producer tag on each bus
- bus_value  in  SIZE*BUS_COUNT  result on each bus

## Operation
- Entry FSM states are EMPTY, WAITING and READY.
  - EMPTY -> WAITING on alloc_valid & alloc_ready when at least one operand is not loaded after allocation.
  - EMPTY -> READY on the same condition when all operands are loaded after allocation.
  - WAITING -> READY in the cycle after the last operand captures.
  - READY -> EMPTY on dispatch.
  - Any state -> EMPTY on flush.
- Priority, highest first: reset, flush, dispatch, allocate, bus capture.
- Allocation, per operand i:
  - If preload[i]=1, then loaded[i]<=1 and value[i]<=alloc_value[i].
  - Otherwise loaded[i]<=0 and the tag is stored in internal saved_tag[i].
- Bus capture applies to each operand with loaded[i]=0 in WAITING:
  - The lowest-index bus k with bus_asserted[k] & bus_source[k]==saved_tag[i] wins.
  - On a match, loaded[i]<=1 and value[i]<=bus_value[k].
  - Several operands may capture in the same cycle, from the same bus or different buses.
- A loaded operand never changes value until the next allocation.
- Assertions of alloc_valid while alloc_ready=0 are ignored, with no state change.
- dispatch while not READY is ignored.
- flush during WAITING abandons any pending capture.
  - After flush, loaded is all 0 and value holds its old contents, which are don't-care.
- Tags are compared at full STATION_INDEX_SIZE width with no wrap semantics.

## Timing
- Reset values: state EMPTY, alloc_ready=1, occupied=0, ready=0, loaded=0, value=0, saved_tag=0.
- Allocation latency is 1 cycle: occupied and loaded reflect the allocation after the accepting edge.
- Capture latency is 1 cycle: loaded[i] and value[i] update on the edge ending the matching bus cycle.
- ready rises 1 cycle after the final capture and is a registered output.
- alloc_ready is combinational from state. The entry cannot be reallocated in its dispatch cycle; alloc_ready returns 1 the cycle after dispatch.
- reset asserted mid-operation forces the reset values on the next edge, regardless of any other input.

## Configuration
- STATION_ALLOC_BYPASS_EN defined:
  - In the allocation cycle, each non-preloaded operand also snoops the buses using alloc_source[i] as the tag.
  - On a match, the operand allocates already loaded with the bus value.
  - The entry goes directly to READY if every operand is then loaded.
- STATION_ALLOC_BYPASS_EN undefined:
  - No snoop in the allocation cycle; a result broadcast in that cycle is missed.
  - Issue logic must preload such operands instead.

## Structure
- The shared definitions header holds:
  - the flat-array macros,
  - the FSM state encodings (EMPTY=2'd0, WAITING=2'd1, READY=2'd2),
  - the tag-match helper macro.
- Sub-module station_operand_slot, instantiated OPERAND_COUNT times via generate:
  - contains one operand's loaded, value and saved_tag registers plus its bus-priority match;
  - the FSM stays in station_operand_set.

## Test plan
All scenarios use SIZE=32, STATION_INDEX_SIZE=2, BUS_COUNT=2, OPERAND_COUNT=2.
- Reset, then allocate with preload=2'b11 and values 0x11, 0x22 -> after 1 edge: ready=1, value={0x22,0x11}, alloc_ready=0. Then dispatch -> EMPTY, alloc_ready=1 the cycle after.
- Allocate with preload=2'b00 and tags {2,1}. Bus0 carries tag 1 with 0xAA; two cycles later bus1 carries tag 2 with 0xBB -> loaded goes 01 then 11, and ready rises the cycle after the second capture.
- Both buses assert tag 3 in the same cycle (bus0=0x5, bus1=0x6) with both operands waiting on tag 3 -> both capture 0x5.
- flush while WAITING, with tag 1 on bus0 in the same cycle -> EMPTY, loaded=00, no capture. A later alloc_valid is accepted.
- Allocate with preload=2'b00 and tag 1 while bus0 asserts tag 1 with 0x77 in the same cycle:
  - STATION_ALLOC_BYPASS_EN defined -> operand 0 is loaded with 0x77;
  - macro undefined -> operand 0 waits, loaded[0]=0.
- reset asserted while READY, with dispatch and alloc_valid also high -> all outputs return to their reset values after 1 edge.

Source files
------------

// File: rtl/station_operand_set_pkg.sv
// Shared definitions for the reservation-station operand set: entry states and
// the allocation target helper. Optional feature macro: STATION_ALLOC_BYPASS_EN.
package station_operand_set_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_WAITING = 2'd1,
      ST_READY   = 2'd2
   } entry_state_t;

   // An allocation lands in READY only when nothing is left to capture.
   function automatic entry_state_t alloc_target(input logic all_loaded);
      return all_loaded ? ST_READY : ST_WAITING;
   endfunction

endpackage

// File: rtl/station_operand_slot.sv
// One operand of a reservation-station entry: loaded flag, value, producer tag and
// lowest-index-bus tag match. STATION_ALLOC_BYPASS_EN enables allocation-cycle snooping.
module station_operand_slot
   import station_operand_set_pkg::*;
#(
   parameter int SIZE               = 32,
   parameter int STATION_INDEX_SIZE = 1,
   parameter int BUS_COUNT          = 1
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    clear,
   input  logic                                    alloc,
   input  logic                                    capture_en,
   input  logic                                    alloc_preload,
   input  logic [SIZE-1:0]                         alloc_value,
   input  logic [STATION_INDEX_SIZE-1:0]           alloc_source,
   input  logic [BUS_COUNT-1:0]                    bus_asserted,
   input  logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source,
   input  logic [SIZE*BUS_COUNT-1:0]               bus_value,
   output logic                                    alloc_loaded,
   output logic                                    loaded,
   output logic [SIZE-1:0]                         value
);

   logic [STATION_INDEX_SIZE-1:0] saved_tag;
   logic                          cap_hit;
   logic [SIZE-1:0]               cap_value;
   logic                          byp_hit;
   logic [SIZE-1:0]               byp_value;

   // Descending scan so the lowest-index matching bus is the one left standing.
   always_comb begin
      cap_hit   = 1'b0;
      cap_value = '0;
      byp_hit   = 1'b0;
      byp_value = '0;
      for (int k = BUS_COUNT - 1; k >= 0; k--) begin
         if (bus_asserted[k] &&
             bus_source[k*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] == saved_tag) begin
            cap_hit   = 1'b1;
            cap_value = bus_value[k*SIZE +: SIZE];
         end
         if (bus_asserted[k] &&
             bus_source[k*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] == alloc_source) begin
            byp_hit   = 1'b1;
            byp_value = bus_value[k*SIZE +: SIZE];
         end
      end
   end

`ifdef STATION_ALLOC_BYPASS_EN
   assign alloc_loaded = alloc_preload | byp_hit;
`else
   assign alloc_loaded = alloc_preload;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         loaded    <= 1'b0;
         value     <= '0;
         saved_tag <= '0;
      end else if (clear) begin
         loaded <= 1'b0;
      end else if (alloc) begin
         saved_tag <= alloc_source;
         if (alloc_preload) begin
            loaded <= 1'b1;
            value  <= alloc_value;
         end else begin
`ifdef STATION_ALLOC_BYPASS_EN
            loaded <= byp_hit;
            if (byp_hit)
               value <= byp_value;
`else
            loaded <= 1'b0;
`endif
         end
      end else if (capture_en && !loaded && cap_hit) begin
         loaded <= 1'b1;
         value  <= cap_value;
      end
   end

endmodule

// File: rtl/station_operand_set.sv
// Reservation-station entry: EMPTY/WAITING/READY control around OPERAND_COUNT operand
// slots. STATION_ALLOC_BYPASS_EN lets operands capture a bus result while allocating.
module station_operand_set
   import station_operand_set_pkg::*;
#(
   parameter int SIZE               = 32,
   parameter int STATION_INDEX_SIZE = 1,
   parameter int BUS_COUNT          = 1,
   parameter int OPERAND_COUNT      = 2
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        alloc_valid,
   output logic                                        alloc_ready,
   input  logic [OPERAND_COUNT-1:0]                    alloc_preload,
   input  logic [SIZE*OPERAND_COUNT-1:0]               alloc_value,
   input  logic [STATION_INDEX_SIZE*OPERAND_COUNT-1:0] alloc_source,
   input  logic                                        dispatch,
   input  logic                                        flush,
   output logic                                        occupied,
   output logic                                        ready,
   output logic [OPERAND_COUNT-1:0]                    loaded,
   output logic [SIZE*OPERAND_COUNT-1:0]               value,
   input  logic [BUS_COUNT-1:0]                        bus_asserted,
   input  logic [STATION_INDEX_SIZE*BUS_COUNT-1:0]     bus_source,
   input  logic [SIZE*BUS_COUNT-1:0]                   bus_value
);

   entry_state_t             state;
   entry_state_t             state_next;
   logic                     clear;
   logic                     alloc;
   logic                     capture_en;
   logic [OPERAND_COUNT-1:0] alloc_loaded;

   always_ff @(posedge clock) begin
      if (reset)
         state <= ST_EMPTY;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY:   if (alloc_valid) state_next = alloc_target(&alloc_loaded);
            ST_WAITING: if (&loaded)     state_next = ST_READY;
            ST_READY:   if (dispatch)    state_next = ST_EMPTY;
            default:                     state_next = ST_EMPTY;
         endcase
      end
   end

   // A dispatched or flushed entry empties its slots; allocation only from EMPTY.
   always_comb begin
      alloc_ready = (state == ST_EMPTY);
      occupied    = (state != ST_EMPTY);
      ready       = (state == ST_READY);
      clear       = flush | (dispatch & (state == ST_READY));
      alloc       = alloc_valid & (state == ST_EMPTY) & ~flush;
      capture_en  = (state == ST_WAITING);
   end

   for (genvar i = 0; i < OPERAND_COUNT; i++) begin : g_slot
      station_operand_slot #(
         .SIZE               (SIZE),
         .STATION_INDEX_SIZE (STATION_INDEX_SIZE),
         .BUS_COUNT          (BUS_COUNT)
      ) u_slot (
         .clock         (clock),
         .reset         (reset),
         .clear         (clear),
         .alloc         (alloc),
         .capture_en    (capture_en),
         .alloc_preload (alloc_preload[i]),
         .alloc_value   (alloc_value[i*SIZE +: SIZE]),
         .alloc_source  (alloc_source[i*STATION_INDEX_SIZE +: STATION_INDEX_SIZE]),
         .bus_asserted  (bus_asserted),
         .bus_source    (bus_source),
         .bus_value     (bus_value),
         .alloc_loaded  (alloc_loaded[i]),
         .loaded        (loaded[i]),
         .value         (value[i*SIZE +: SIZE])
      );
   end

endmodule
